// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter with SLL/SRL/SRA/ROL/ROR and pass-through.
// Stage k applies the 2^k shift layer. Each stage uses valid/ready flow control,
// so the unit accepts one operation per cycle unless the output side stalls.
module shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [SHW-1:0]   ShAmt,
    input  logic [2:0]       Mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // Per-stage state: valid flag, partial result, and the operation's context.
    logic             v    [SHW];
    logic [WIDTH-1:0] data [SHW];
    logic [SHW-1:0]   amt  [SHW];
    logic [2:0]       mode [SHW];
    logic             sign [SHW];
    logic [TAG_W-1:0] tag  [SHW];
    logic [SHW-1:0]   ready;

    // Applies one shift layer of 'sh' bit positions. SRA fills with the original
    // operand's sign bit, not with the partial result's current MSB.
    function automatic logic [WIDTH-1:0] layer(input logic [WIDTH-1:0] d,
                                               input logic [2:0]       m,
                                               input logic             s,
                                               input int unsigned      sh);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SLL: r = d << sh;
            MODE_SRL: r = d >> sh;
            MODE_SRA: r = (d >> sh) | (s ? ~({WIDTH{1'b1}} >> sh) : '0);
            MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
            MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
            default:  r = d;
        endcase
        return r;
    endfunction

    // Ready chain. A stage can advance if it is empty or if every later stage
    // can also advance. This is written as an OR over all later stages so that
    // no ready bit feeds another ready bit.
    always_comb begin
        // NOTE: give every combinational output a default before any branch or
        // loop, so that no path leaves it unassigned and no latch is inferred.
        ready = '0;
        for (int k = 0; k < SHW; k++) begin
            logic acc;
            acc = out_ready;
            for (int j = k; j < SHW; j++) begin
                acc = acc | ~v[j];
            end
            ready[k] = acc;
        end
    end

    // Pipeline advance. A stage with ready=0 holds its fields. A bubble is
    // overwritten because an empty stage is always ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every stage register is reset, not only the valid flags.
            // This makes Out and out_tag read 0 right after reset, including
            // a reset that arrives mid-stream.
            for (int k = 0; k < SHW; k++) begin
                v[k]    <= 1'b0;
                data[k] <= '0;
                amt[k]  <= '0;
                mode[k] <= '0;
                sign[k] <= 1'b0;
                tag[k]  <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments. Each stage
            // therefore reads its predecessor's value from before this edge.
            if (ready[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    data[0] <= ShAmt[0] ? layer(In, Mode, In[WIDTH-1], 32'd1) : In;
                    amt[0]  <= ShAmt;
                    mode[0] <= Mode;
                    sign[0] <= In[WIDTH-1];
                    tag[0]  <= in_tag;
                end
            end
            for (int k = 1; k < SHW; k++) begin
                if (ready[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        data[k] <= amt[k-1][k]
                                   ? layer(data[k-1], mode[k-1], sign[k-1], 32'd1 << k)
                                   : data[k-1];
                        amt[k]  <= amt[k-1];
                        mode[k] <= mode[k-1];
                        sign[k] <= sign[k-1];
                        tag[k]  <= tag[k-1];
                    end
                end
            end
        end
    end

    // The outputs come straight from the last stage's registers.
    assign in_ready  = ready[0];
    assign out_valid = v[SHW-1];
    assign Out       = data[SHW-1];
    assign out_tag   = tag[SHW-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: self-checking bench for shifter_pipe with WIDTH=16.
// Inputs are driven on the falling edge and sampled 1 time unit later.
// Expected results come from an arithmetic reference model feeding a scoreboard queue.
module tb_shifter_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] In;
    logic [3:0]  ShAmt;
    logic [2:0]  Mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Out;
    logic [3:0]  out_tag;

    int total = 0;
    int bad   = 0;
    logic [19:0] exp_q[$];   // {expected result, tag}

    shifter_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .In(In), .ShAmt(ShAmt), .Mode(Mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference model built directly from the operation definitions.
    function automatic logic [15:0] model(input logic [15:0] a, input int s, input logic [2:0] m);
        logic [31:0]        dbl;
        logic signed [15:0] sa;
        logic [15:0]        r;
        dbl = {a, a};
        sa  = a;
        case (m)
            3'd0:    r = a << s;
            3'd1:    r = a >> s;
            3'd2:    r = sa >>> s;
            3'd3:    begin dbl = dbl << s; r = dbl[31:16]; end
            3'd4:    begin dbl = dbl >> s; r = dbl[15:0];  end
            default: r = a;
        endcase
        return r;
    endfunction

    // One cycle: drive at the falling edge, then score the handshakes that the
    // next rising edge will perform.
    task automatic step(input logic iv, input logic [15:0] d, input logic [3:0] s,
                        input logic [2:0] m, input logic [3:0] t, input logic ordy,
                        output logic acc, output logic ret);
        @(negedge clk);
        in_valid  = iv;
        In        = d;
        ShAmt     = s;
        Mode      = m;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        ret = out_valid && ordy;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                check("out_data", 32'(Out), 32'(exp_q[0][19:4]));
                check("out_tag", 32'(out_tag), 32'(exp_q[0][3:0]));
                if (ret) void'(exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back({model(d, int'(s), m), t});
    endtask

    task automatic idle(input logic ordy);
        logic a, r;
        step(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, ordy, a, r);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) idle(1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Issue one op into an empty pipe and check that it appears exactly 4 edges later.
    task automatic single(input logic [15:0] d, input logic [3:0] s, input logic [2:0] m,
                          input logic [3:0] t, input logic [15:0] want);
        logic a, r;
        check("model_vs_table", 32'(model(d, int'(s), m)), 32'(want));
        step(1'b1, d, s, m, t, 1'b1, a, r);
        check("single_accept", 32'(a), 32'd1);
        for (int i = 1; i < 4; i++) begin
            idle(1'b1);
            check("single_early", 32'(out_valid), 32'd0);
        end
        idle(1'b1);
        check("single_latency", 32'(out_valid), 32'd1);
        check("single_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic        a, r;
    logic [15:0] op_d[6];
    logic [3:0]  op_s[6];
    logic [2:0]  op_m[6];
    logic [3:0]  op_t[6];
    int          p, acc_cnt, ret_cnt, first_ret, second_ret, cyc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; In = '0; ShAmt = '0; Mode = '0; in_tag = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(Out), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #10 rst_n = 1'b1;

        // Basic ops, rotates and pass-through.
        single(16'h00FF, 4'd8,  3'd0, 4'h1, 16'hFF00);
        single(16'h8001, 4'd1,  3'd1, 4'h2, 16'h4000);
        single(16'h8000, 4'd15, 3'd2, 4'h3, 16'hFFFF);
        single(16'h7FF0, 4'd4,  3'd2, 4'h4, 16'h07FF);
        single(16'h8001, 4'd1,  3'd3, 4'h5, 16'h0003);
        single(16'h0001, 4'd4,  3'd4, 4'h6, 16'h1000);
        single(16'hABCD, 4'd0,  3'd4, 4'h7, 16'hABCD);
        single(16'h1234, 4'd5,  3'd7, 4'h8, 16'h1234);

        // Back-to-back: 16 random ops, one result per cycle from the 4th step on.
        for (int i = 0; i < 20; i++) begin
            if (i < 16)
                step(1'b1, 16'($urandom), 4'($urandom_range(15)), 3'($urandom_range(7)),
                     4'($urandom), 1'b1, a, r);
            else
                idle(1'b1);
            if (i < 16) check("b2b_in_ready", 32'(in_ready), 32'd1);
            check("b2b_out_valid", 32'(out_valid), 32'(i >= 4));
        end
        drain(10);

        // Backpressure: present 6 ops with out_ready=0; only 4 fit.
        for (int i = 0; i < 6; i++) begin
            op_d[i] = 16'($urandom); op_s[i] = 4'($urandom_range(15));
            op_m[i] = 3'($urandom_range(4)); op_t[i] = 4'($urandom);
        end
        p = 0; acc_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, op_d[p], op_s[p], op_m[p], op_t[p], 1'b0, a, r);
            check("bp_in_ready", 32'(in_ready), 32'(c < 4));
            if (a) begin p++; acc_cnt++; end
        end
        check("bp_accepted", 32'(acc_cnt), 32'd4);
        ret_cnt = 0;
        for (int c = 0; c < 20 && (p < 6 || exp_q.size() != 0); c++) begin
            if (p < 6) step(1'b1, op_d[p], op_s[p], op_m[p], op_t[p], 1'b1, a, r);
            else       step(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b1, a, r);
            if (c == 0) check("bp_release_in_ready", 32'(in_ready), 32'd1);
            if (a) p++;
            if (r) ret_cnt++;
        end
        check("bp_retired", 32'(ret_cnt), 32'd6);
        check("bp_empty", 32'(exp_q.size()), 32'd0);

        // Bubble collapse: A, two idle cycles, B, all with out_ready=0.
        step(1'b1, 16'h0F0F, 4'd3, 3'd3, 4'hA, 1'b0, a, r);
        check("bub_acc_a", 32'(a), 32'd1);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 16'hF00F, 4'd7, 3'd2, 4'hB, 1'b0, a, r);
        check("bub_acc_b", 32'(a), 32'd1);
        for (int i = 0; i < 4; i++) idle(1'b0);
        first_ret = -1; second_ret = -1;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b1, a, r);
            if (r) begin
                if (first_ret < 0) first_ret = c;
                else if (second_ret < 0) second_ret = c;
            end
        end
        check("bub_consecutive", 32'(second_ret - first_ret), 32'd1);
        check("bub_empty", 32'(exp_q.size()), 32'd0);

        // Async reset with 3 ops in flight and one result on the output.
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'($urandom), 4'($urandom_range(15)), 3'($urandom_range(4)),
                 4'($urandom), 1'b0, a, r);
        idle(1'b0);
        idle(1'b0);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out", 32'(Out), 32'd0);
        check("mid_rst_out_tag", 32'(out_tag), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            check("post_rst_no_out", 32'(out_valid), 32'd0);
        end
        single(16'h0F00, 4'd2, 3'd1, 4'hC, 16'h03C0);

        // Extra random single-issue coverage over all modes.
        for (cyc = 0; cyc < 6; cyc++) begin
            logic [15:0] d;
            logic [3:0]  s;
            logic [2:0]  m;
            d = 16'($urandom); s = 4'($urandom_range(15)); m = 3'($urandom_range(7));
            single(d, s, m, 4'(cyc), model(d, int'(s), m));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, pipelined barrel shifter supporting logical, arithmetic and rotate operations with valid/ready flow control on both sides. Each pipeline stage applies one power-of-two shift layer, so a new operation can be accepted every cycle while the output side is not stalled. It sits between the ALU operand muxes and the execute-stage result bus, and replaces single-mode combinational shifters wherever a registered, back-pressurable shift unit is needed.

## Interface

**Parameters**

- `WIDTH`, default 16: data width. Must be a power of two, ≥ 2.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width, and also the pipeline depth. Derived; not overridden.
- `TAG_W`, default 4: width of the opaque sideband tag carried alongside each operation.

**Ports**

- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous assert, active-low.
- `in_valid`, input, 1: an operation is presented on `In`/`ShAmt`/`Mode`/`in_tag`.
- `in_ready`, output, 1: stage 0 can accept this cycle.
- `In`, input, WIDTH: operand.
- `ShAmt`, input, SHW: shift amount, 0 to WIDTH-1.
- `Mode`, input, 3: operation select.
  - 000 SLL
  - 001 SRL
  - 010 SRA
  - 011 ROL
  - 100 ROR
  - 101–111 pass-through: result = `In`.
- `in_tag`, input, TAG_W: sideband. Returned unmodified with the result.
- `out_valid`, output, 1: `Out`/`out_tag` hold a completed result.
- `out_ready`, input, 1: consumer accepts the result this cycle.
- `Out`, output, WIDTH: shift result.
- `out_tag`, output, TAG_W: tag of the result on `Out`.

## Operation

- **Pipeline structure:** SHW stages, numbered 0 to SHW-1.
  - Stage k holds `v[k]`, data, the full ShAmt, Mode and tag.
- **Stage 0 capture:** on a handshake, stage 0 registers the result of applying shift layer 2^0 to `In`, conditioned on `ShAmt[0]`.
- **Stage k transfer (k ≥ 1):** stage k registers stage k-1 data with layer 2^k applied, conditioned on `ShAmt[k]`.
- **Layer fill behaviour:**
  - SLL: zero-fill from the LSB side.
  - SRL: zero-fill from the MSB side.
  - SRA: fill with the operand sign bit. The sign bit is bit WIDTH-1 of the original operand, carried through every stage; it is not recomputed from the partial result.
  - ROL/ROR: bits shifted out re-enter at the opposite end.
  - Pass-through: every layer is the identity.
- **Result:** `Out`, `out_tag` and `out_valid` are driven directly from stage SHW-1 registers; there is no output combinational logic.
- **Ready chain:**
  - `ready[SHW-1] = !v[SHW-1] | out_ready`
  - `ready[k] = !v[k] | ready[k+1]`
  - `in_ready = ready[0]`
  - This is a purely combinational chain. A stage advances when its own `ready` is 1.
- **Valid propagation:** when `ready[k]` is 1:
  - `v[0] <= in_valid`
  - `v[k] <= v[k-1]` for k ≥ 1
- **Stalled stage:** a stage whose `ready` is 0 holds all of its fields unchanged.
- **Bubbles:** a bubble (`v=0`) is overwritten even while downstream stages are stalled, so bubbles collapse.
- **Hazards:** none. Operations are independent, and results leave strictly in acceptance order.
- **ShAmt = 0:** result equals `In` for every Mode.
- **Reset:** asserting `rst_n` low at any time, including mid-stream, immediately clears all `v[k]`, data and tag registers to 0. In-flight operations are discarded without any output.

## Timing

- **Reset values:**
  - `out_valid` = 0
  - `Out` = 0
  - `out_tag` = 0
  - `in_ready` = 1, because it follows combinationally from the empty pipeline.
- **Latency:** an operation accepted at edge N is presented on `Out` with `out_valid`=1 after edge N+SHW-1, i.e. it is visible for the cycle following edge N+SHW-1. This holds if no stall occurs. With WIDTH=16 the latency is 4 edges from acceptance to registered output.
- **Throughput:** 1 operation per cycle while `out_ready`=1.
- **Stalls:**
  - `out_ready`=0 with a full pipeline drops `in_ready` to 0 in the same cycle.
  - A full pipeline holds exactly SHW operations.
- **Simultaneous accept and consume:** `in_valid`, `in_ready`, `out_valid` and `out_ready` all high in one cycle both accepts and retires, and occupancy is unchanged.
- **Output stability:** `Out`/`out_tag` remain stable while `out_valid`=1 and `out_ready`=0.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready`. No other input-to-output combinational path exists.

## Test plan

All scenarios use WIDTH=16.

- **Basic ops, single-issue:** each case is checked after 4 edges, with its tag echoed.
  - SLL 0x00FF by 8 -> 0xFF00
  - SRL 0x8001 by 1 -> 0x4000
  - SRA 0x8000 by 15 -> 0xFFFF
  - SRA 0x7FF0 by 4 -> 0x07FF
- **Rotates and pass-through:**
  - ROL 0x8001 by 1 -> 0x0003
  - ROR 0x0001 by 4 -> 0x1000
  - ROR 0xABCD by 0 -> 0xABCD
  - Mode=111, 0x1234 by 5 -> 0x1234
- **Back-to-back throughput:** 16 random ops with `out_ready`=1.
  - Results match a reference model in order, one per cycle, starting 4 cycles after the first accept.
  - `in_ready` never drops.
- **Backpressure:** fill with 6 ops while holding `out_ready`=0.
  - Exactly 4 are accepted; `in_ready` goes 0 after the 4th.
  - Output holds the first result stable.
  - Releasing `out_ready` drains all 6 in order with no loss or duplication.
- **Bubble collapse:** issue op A, idle 2 cycles, issue op B, with `out_ready`=0 until both are inside.
  - After release, A and B appear on consecutive cycles.
- **Async reset mid-stream:** pulse `rst_n` low between edges with 3 ops in flight.
  - `out_valid` goes to 0 immediately and `Out`=0.
  - No discarded result ever appears.
  - The next op after release returns after 4 edges.
